// File: rtl/pixel_buf_ctrl.sv
`default_nettype none
// ============================================================================
// pixel_buf_ctrl : circular pixel queue sequencing a registered-read dual-port
//                  buffer; PIXBUF_ERR_EN adds sticky ovf_err/udf_err flags.
// Revision       : 1.0
// ============================================================================
module pixel_buf_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [ADDR_WIDTH:0]   level,
`ifdef PIXBUF_ERR_EN
  output logic                  ovf_err,
  output logic                  udf_err,
`endif
  output logic                  buf_w_ena,
  output logic [ADDR_WIDTH-1:0] buf_w_addr,
  output logic [WIDTH-1:0]      buf_w_data,
  output logic                  buf_r_ena,
  output logic [ADDR_WIDTH-1:0] buf_r_addr,
  input  logic [WIDTH-1:0]      buf_r_data
);

  localparam logic [ADDR_WIDTH:0]   c_full_level = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_level_one  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_m_valid;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic                  w_push;
  logic                  w_rd;

  // rst_n gating keeps both strobes low during an asynchronous reset
  assign s_ready = rst_n && !flush && (r_level != c_full_level);
  assign w_push  = s_valid && s_ready;
  assign w_rd    = rst_n && !flush && (r_level != '0) && (!r_m_valid || m_ready);

  assign buf_w_ena  = w_push;
  assign buf_w_addr = r_wptr;
  assign buf_w_data = s_data;
  assign buf_r_ena  = w_rd;
  assign buf_r_addr = r_rptr;

  assign m_valid = r_m_valid;
  assign m_data  = buf_r_data;
  assign level   = r_level;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_rd) begin
      w_level_nxt = r_level + c_level_one;
    end else if (!w_push && w_rd) begin
      w_level_nxt = r_level - c_level_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_m_valid <= 1'b0;
    end else if (flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      r_level <= w_level_nxt;
      // buffer output only changes on a read issue, so m_data holds otherwise
      if (w_rd) begin
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef PIXBUF_ERR_EN
  logic r_ovf_err;
  logic r_udf_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else if (flush) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (s_valid && !s_ready) begin
        r_ovf_err <= 1'b1;
      end
      if (m_ready && !r_m_valid) begin
        r_udf_err <= 1'b1;
      end
    end
  end

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_buf_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pixel_buf_ctrl : directed + random checks of pixel_buf_ctrl against a
//                     queue reference model, with a behavioural buffer RAM.
// Revision          : 1.0
// ============================================================================
module tb_pixel_buf_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] level;
`ifdef PIXBUF_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif
  logic       buf_w_ena;
  logic [3:0] buf_w_addr;
  logic [7:0] buf_w_data;
  logic       buf_r_ena;
  logic [3:0] buf_r_addr;
  logic [7:0] buf_r_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] mem [16];

  pixel_buf_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level),
`ifdef PIXBUF_ERR_EN
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
`endif
    .buf_w_ena  (buf_w_ena),
    .buf_w_addr (buf_w_addr),
    .buf_w_data (buf_w_data),
    .buf_r_ena  (buf_r_ena),
    .buf_r_addr (buf_r_addr),
    .buf_r_data (buf_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple dual-port RAM with registered read
  always_ff @(posedge clk) begin
    if (buf_w_ena) mem[buf_w_addr] <= buf_w_data;
    if (buf_r_ena) buf_r_data <= mem[buf_r_addr];
  end

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Reference: everything accepted and not yet consumed, in order; the head
  // is the output pixel whenever m_valid is high.
  task automatic observe();
    int exp_level;
    exp_level = model_q.size() - (m_valid ? 1 : 0);
    chk("level", 32'(level), exp_level);
    chk("s_ready", 32'(s_ready), 32'(!flush && exp_level != 16));
    if (m_valid) begin
      chk("m_valid_nonempty", 32'(model_q.size() != 0), 32'd1);
      if (model_q.size() != 0) chk("m_data", 32'(m_data), 32'(model_q[0]));
    end
    if (hold_prev) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_data));
    end
    if (buf_w_ena && buf_r_ena) chk("addr_hazard", 32'(buf_w_addr != buf_r_addr), 32'd1);
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    if (flush) begin
      model_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (m_valid && m_ready && model_q.size() != 0) void'(model_q.pop_front());
      if (s_valid && s_ready) model_q.push_back(s_data);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    observe();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((m_valid || level != 0) && n < 100) begin
      sample();
      adv();
      n++;
    end
    chk("drain_bound", 32'(n < 100), 32'd1);
    m_ready = 1'b0;
  endtask

  initial begin
    int first, last, outs, pushed, popped, n;
    bit got;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    sample();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_w_ena", 32'(buf_w_ena), 32'd0);
    chk("rst_r_ena", 32'(buf_r_ena), 32'd0);
    chk("rst_w_addr", 32'(buf_w_addr), 32'd0);
    chk("rst_r_addr", 32'(buf_r_addr), 32'd0);
    adv();

    // first-out latency with three pushes and no consumer
    s_valid = 1'b1; s_data = 8'h11;
    sample(); chk("lat_mv_c0", 32'(m_valid), 32'd0); adv();
    s_data = 8'h22;
    sample(); chk("lat_mv_c1", 32'(m_valid), 32'd0); chk("lat_lvl_c1", 32'(level), 32'd1); adv();
    s_data = 8'h33;
    sample(); chk("lat_mv_c2", 32'(m_valid), 32'd1); chk("lat_data", 32'(m_data), 32'h11); adv();
    s_valid = 1'b0;
    sample(); chk("lat_lvl_final", 32'(level), 32'd2); adv();
    drain();

    // fill to capacity: 16 in RAM plus one in the output register
    s_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_data = 8'(i);
      sample(); chk("fill_ready", 32'(s_ready), 32'd1); adv();
    end
    s_data = 8'h11;
    sample();
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_w_ena", 32'(buf_w_ena), 32'd0);
    chk("full_head", 32'(m_data), 32'h00);
    adv();
`ifdef PIXBUF_ERR_EN
    chk("ovf_err_set", 32'(ovf_err), 32'd1);
`endif
    m_ready = 1'b1;
    sample(); chk("full_pop_ready", 32'(s_ready), 32'd0); chk("full_pop_r_ena", 32'(buf_r_ena), 32'd1); adv();
    sample(); chk("after_pop_ready", 32'(s_ready), 32'd1); adv();
    drain();

    // streaming 0..63, pointers wrap four times
    m_ready = 1'b1; first = -1; last = -1; outs = 0;
    for (int c = 0; c < 70; c++) begin
      s_valid = (c < 64);
      s_data = 8'(c);
      sample();
      if (m_valid && m_ready) begin
        chk("stream_order", 32'(m_data), 32'(outs));
        if (first < 0) first = c;
        last = c;
        outs++;
      end
      adv();
    end
    chk("stream_count", outs, 64);
    chk("stream_first", first, 2);
    chk("stream_gapless", last - first, 63);
    drain();

    // random handshakes, 1000 pixels
    pushed = 0; popped = 0; n = 0;
    while ((pushed < 1000 || m_valid || level != 0) && n < 20000) begin
      s_valid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      sample();
      if (s_valid && s_ready) pushed++;
      if (m_valid && m_ready) popped++;
      adv();
      n++;
    end
    chk("rand_bound", 32'(n < 20000), 32'd1);
    chk("rand_popped", popped, 1000);
    chk("rand_model_empty", model_q.size(), 0);

    // flush with level 9 and a held output pixel
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(8'hC0 + i);
      sample(); adv();
    end
    s_valid = 1'b0;
    sample(); chk("pre_flush_level", 32'(level), 32'd9); chk("pre_flush_mv", 32'(m_valid), 32'd1); adv();
`ifdef PIXBUF_ERR_EN
    chk("udf_err_set", 32'(udf_err), 32'd1);
`endif
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    sample();
    chk("flush_s_ready", 32'(s_ready), 32'd0);
    chk("flush_w_ena", 32'(buf_w_ena), 32'd0);
    chk("flush_r_ena", 32'(buf_r_ena), 32'd0);
    adv();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    sample();
    chk("post_flush_level", 32'(level), 32'd0);
    chk("post_flush_mv", 32'(m_valid), 32'd0);
    chk("post_flush_ready", 32'(s_ready), 32'd1);
`ifdef PIXBUF_ERR_EN
    chk("flush_ovf_clr", 32'(ovf_err), 32'd0);
    chk("flush_udf_clr", 32'(udf_err), 32'd0);
`endif
    adv();
    s_valid = 1'b1; s_data = 8'hAB;
    sample(); adv();
    s_valid = 1'b0; m_ready = 1'b1; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      sample();
      if (m_valid) begin
        chk("flush_next_pixel", 32'(m_data), 32'hAB);
        got = 1'b1;
      end
      adv();
    end
    chk("flush_next_seen", 32'(got), 32'd1);
    drain();

    // asynchronous reset mid-stream
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(8'h50 + i);
      sample(); adv();
    end
    m_ready = 1'b1;
    sample();
    chk("pre_arst_level", 32'(level != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_w_ena", 32'(buf_w_ena), 32'd0);
    chk("arst_r_ena", 32'(buf_r_ena), 32'd0);
    model_q.delete();
    hold_prev = 1'b0;
    adv();
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    sample(); chk("post_arst_ready", 32'(s_ready), 32'd1); adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_buf_ctrl.md
# pixel_buf_ctrl

Controller that sequences a simple dual-port `buffer` instance as a circular pixel queue. The draw/rasterizer side pushes pixels through a valid/ready port, and the VGA scanout side pops them through a valid/ready port. The block owns all `buffer` address, enable and data-steering signals. It hides the RAM's one-cycle registered read, sustains one pixel per clock in each direction, and supports a synchronous flush at line or frame boundaries.

## Interface
- `WIDTH`, 8, pixel width; must equal the `buffer` WIDTH.
- `DEPTH`, 16, queue capacity in entries; must equal 2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, 4, buffer address width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear; highest priority after reset.
- `s_valid`  in  1  producer has a pixel.
- `s_ready`  out  1  queue can accept a pixel.
- `s_data`  in  WIDTH  producer pixel.
- `m_valid`  out  1  `m_data` holds a valid pixel.
- `m_ready`  in  1  scanout consumes the pixel.
- `m_data`  out  WIDTH  scanout pixel; wired directly from `buf_r_data`.
- `level`  out  ADDR_WIDTH+1  number of entries stored in RAM, excluding the output pixel.
- `buf_w_ena`  out  1  buffer write enable.
- `buf_w_addr`  out  ADDR_WIDTH  buffer write address.
- `buf_w_data`  out  WIDTH  buffer write data; equals `s_data`.
- `buf_r_ena`  out  1  buffer read enable.
- `buf_r_addr`  out  ADDR_WIDTH  buffer read address.
- `buf_r_data`  in  WIDTH  buffer registered read data.

## Operation
- State:
  - `wptr` and `rptr` are ADDR_WIDTH bits wide and wrap modulo DEPTH.
  - `level` is ADDR_WIDTH+1 bits wide.
  - `m_valid` is a register.
- Push:
  - `s_ready = (level != DEPTH)`.
  - Push event is `s_valid && s_ready`; it drives `buf_w_ena`=1 and `buf_w_addr`=`wptr`, and increments `wptr`.
- Read issue:
  - `buf_r_ena = (level != 0) && (!m_valid || m_ready)`; `buf_r_addr`=`rptr`; issuing increments `rptr`.
- Output register:
  - On a read issue, `m_valid`<=1.
  - Otherwise, if `m_ready`, `m_valid`<=0.
  - `m_data` holds because the buffer does not update `r_data` while `buf_r_ena`=0.
- Level:
  - `level` <= `level` + push − read issue.
  - A simultaneous push and read issue leaves `level` unchanged.
- Combinational gating:
  - No combinational path from `m_ready` to `s_ready`.
  - `s_ready` depends only on `level`.
- Same-address hazard:
  - A read issues only when `level`>0 and a write only when `level`<DEPTH.
  - Read and write addresses are therefore never equal in the same cycle; no bypass is needed.
- Flush:
  - Next edge: `wptr`, `rptr`, `level` <= 0 and `m_valid` <= 0.
  - Push and read issue are suppressed in that cycle: `buf_w_ena`=0, `buf_r_ena`=0, `s_ready`=0.
- Reset (asynchronous, any time, including mid-burst): `wptr`=`rptr`=0, `level`=0, `m_valid`=0.

## Timing
- Reset values:
  - `s_ready`=1 (after reset deasserts with `flush`=0).
  - `m_valid`=0, `level`=0, `buf_w_ena`=0, `buf_r_ena`=0, `buf_w_addr`=0, `buf_r_addr`=0.
  - `m_data` is undefined until the first read.
- Latency: a pixel pushed on edge E into an empty queue reaches `level`=1 after E, is read-issued in cycle E+1, and shows `m_valid`=1 with `m_data` after edge E+1. First-out latency is 2 cycles.
- Throughput: with `s_valid`=`m_ready`=1 continuously, one pixel per cycle moves in each direction.
- Total storage: DEPTH entries in RAM plus 1 in the output register.
- `m_valid` and `m_data` stay stable while `m_valid`=1 and `m_ready`=0.
- Full (`level`=DEPTH): `s_ready`=0. A simultaneous pop does not raise `s_ready` in that cycle; it rises the next cycle.
- Empty (`level`=0 and `m_valid`=1 consumed): `m_valid` drops after that edge.

## Configuration
- Macro: `PIXBUF_ERR_EN`.
- Defined: adds outputs `ovf_err` and `udf_err` (1 bit each, sticky, reset 0, cleared by `flush`).
  - `ovf_err` sets on `s_valid && !s_ready`; this excludes cycles where `flush` is high.
  - `udf_err` sets on `m_ready && !m_valid`, meaning scanout starved.
- Undefined: both ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `m_ready`=0:
  - `m_valid` rises 2 cycles after the 0x11 push with `m_data`=0x11.
  - `level` settles at 2.
- Fill test, `m_ready`=0, push 0x00..0x10:
  - 17 pushes accepted; `s_ready`=0 with `level`=16.
  - The 18th push stalls; `ovf_err`=1 if `PIXBUF_ERR_EN`.
- Streaming 0..63 with `s_valid`=`m_ready`=1:
  - Output is 0..63 in order, one per cycle after the initial 2-cycle latency.
  - Pointers wrap 4 times with no gaps.
- Random `s_valid`/`m_ready` patterns, 1000 pixels: output sequence equals the input sequence, and `m_data` is stable whenever `m_valid` && !`m_ready`.
- Assert `flush` with `level`=9 and `m_valid`=1:
  - Next cycle `level`=0, `m_valid`=0, `s_ready`=1.
  - A following push of 0xAB emerges as the next `m_data`.
- Assert `rst_n`=0 asynchronously mid-stream: `m_valid`, `level`, `buf_w_ena` and `buf_r_ena` go to 0 immediately, without a clock edge.
